vga_colorbar_driver: RTL and testbench



---
 rtl/vga_colorbar_driver.sv | 125 ++++++++++++
 tb/tb_vga_colorbar_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_colorbar_driver.sv
// VGA 640x480@60 timing generator with an 8-bar colour test pattern.
// Counters run at a divided pixel rate; sync and RGB are decoded from them.
module vga_colorbar_driver #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    output logic [3:0] O_red,
    output logic [3:0] O_green,
    output logic [3:0] O_blue,
    output logic       O_hs,
    output logic       O_vs
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam int unsigned H_W   = $clog2(H_TOTAL);
    localparam int unsigned V_W   = $clog2(V_TOTAL);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_SYNC_C  = H_W'(H_SYNC);
    localparam logic [V_W-1:0]   V_SYNC_C  = V_W'(V_SYNC);
    localparam logic [H_W-1:0]   H_START_C = H_W'(H_START);
    localparam logic [H_W-1:0]   H_END_C   = H_W'(H_START + H_ACTIVE);
    localparam logic [V_W-1:0]   V_START_C = V_W'(V_START);
    localparam logic [V_W-1:0]   V_END_C   = V_W'(V_START + V_ACTIVE);

    typedef enum logic [2:0] {
        BAR_WHITE,
        BAR_YELLOW,
        BAR_CYAN,
        BAR_GREEN,
        BAR_MAGENTA,
        BAR_RED,
        BAR_BLUE,
        BAR_BLACK
    } bar_t;

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             pix_en;
    logic             active;
    logic [H_W-1:0]   h_off;
    logic [2:0]       bar_num;
    bar_t             bar;
    logic [11:0]      rgb;

    // With CLK_DIV=1 the divider is a constant zero and pix_en stays high.
    assign pix_en = (div_cnt == DIV_LAST);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        active = (h_cnt >= H_START_C) && (h_cnt < H_END_C) &&
                 (v_cnt >= V_START_C) && (v_cnt < V_END_C);
        h_off  = h_cnt - H_START_C;
    end

    // Bar index by threshold compare rather than a divide by BAR_W.
    always_comb begin
        bar_num = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h_off >= H_W'(i * BAR_W))
                bar_num = bar_num + 3'd1;
        end
        bar = bar_t'(bar_num);
    end

    always_comb begin
        rgb = '0;
        if (active) begin
            case (bar)
                BAR_WHITE:   rgb = 12'hFFF;
                BAR_YELLOW:  rgb = 12'hFF0;
                BAR_CYAN:    rgb = 12'h0FF;
                BAR_GREEN:   rgb = 12'h0F0;
                BAR_MAGENTA: rgb = 12'hF0F;
                BAR_RED:     rgb = 12'hF00;
                BAR_BLUE:    rgb = 12'h00F;
                default:     rgb = 12'h000;
            endcase
        end
    end

    always_comb begin
        O_red   = rgb[11:8];
        O_green = rgb[7:4];
        O_blue  = rgb[3:0];
        O_hs    = (h_cnt >= H_SYNC_C);
        O_vs    = (v_cnt >= V_SYNC_C);
    end

endmodule

// File: tb/tb_vga_colorbar_driver.sv
// Directed bench: full-size instance for HS/colour bars, reduced instance for frame-level checks.
module tb_vga_colorbar_driver;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       hs_a, vs_a, hs_b, vs_b;
    logic [11:0] rgb_a, rgb_b;

    assign rgb_a = {red_a, green_a, blue_a};
    assign rgb_b = {red_b, green_b, blue_b};

    vga_colorbar_driver #(.CLK_DIV(2)) dut_a (
        .I_clk(clk), .I_rst_n(rst_a),
        .O_red(red_a), .O_green(green_a), .O_blue(blue_a),
        .O_hs(hs_a), .O_vs(vs_a)
    );

    // Small frame: 28 px/line (active 8..23, bars 2 px), 13 lines (active 5..10), 3 clocks/pixel.
    vga_colorbar_driver #(
        .CLK_DIV(3), .H_SYNC(4), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(6), .V_FP(2)
    ) dut_b (
        .I_clk(clk), .I_rst_n(rst_b),
        .O_red(red_b), .O_green(green_b), .O_blue(blue_b),
        .O_hs(hs_b), .O_vs(vs_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int unsigned edges_a = 0;
    int unsigned edges_b = 0;

    task automatic tick_a();
        @(posedge clk); #1;
        edges_a++;
    endtask

    task automatic tick_b();
        @(posedge clk); #1;
        edges_b++;
    endtask

    task automatic goto_a(input int unsigned pix);
        while (edges_a < 2 * pix) tick_a();
    endtask

    task automatic goto_b(input int unsigned pix);
        while (edges_b < 3 * pix) tick_b();
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (hs_a !== 1'b0) begin n_err++; $display("FAIL reset_hs_a: got %b expected 0", hs_a); end
        n_cmp++; if (vs_a !== 1'b0) begin n_err++; $display("FAIL reset_vs_a: got %b expected 0", vs_a); end
        n_cmp++; if (rgb_a !== 12'h000) begin n_err++; $display("FAIL reset_rgb_a: got %h expected 000", rgb_a); end
        n_cmp++; if ({hs_b, vs_b, rgb_b} !== 14'h0) begin n_err++; $display("FAIL reset_b: got %h expected 0", {hs_b, vs_b, rgb_b}); end
        @(negedge clk);
        rst_a = 1'b1;
        edges_a = 0;
    endtask

    task automatic test_hs_timing();
        int fall [2];
        int rise [2];
        int nf = 0;
        int nr = 0;
        logic prev;
        fall = '{-1, -1};
        rise = '{-1, -1};
        prev = hs_a;
        while (edges_a < 3400) begin
            tick_a();
            if (prev && !hs_a && nf < 2) begin fall[nf] = edges_a; nf++; end
            if (!prev && hs_a && nr < 2) begin rise[nr] = edges_a; nr++; end
            prev = hs_a;
        end
        n_cmp++; if (rise[0] !== 192) begin n_err++; $display("FAIL hs_first_rise: got %0d expected 192", rise[0]); end
        n_cmp++; if (fall[0] !== 1600) begin n_err++; $display("FAIL hs_first_fall: got %0d expected 1600", fall[0]); end
        n_cmp++; if (rise[1] - fall[0] !== 192) begin n_err++; $display("FAIL hs_low_width: got %0d expected 192", rise[1] - fall[0]); end
        n_cmp++; if (fall[1] - fall[0] !== 1600) begin n_err++; $display("FAIL hs_period: got %0d expected 1600", fall[1] - fall[0]); end
    endtask

    task automatic test_vblank_top();
        goto_a(34 * 800 + 200);
        n_cmp++; if (rgb_a !== 12'h000) begin n_err++; $display("FAIL vblank_v34: got %h expected 000", rgb_a); end
        n_cmp++; if (vs_a !== 1'b1) begin n_err++; $display("FAIL vs_v34: got %b expected 1", vs_a); end
    endtask

    task automatic test_colour_bars();
        int unsigned h_tab [14] = '{143, 144, 200, 223, 224, 304, 384, 464, 544, 624, 703, 704, 783, 784};
        logic [11:0] exp_tab [14] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                      12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000, 12'h000, 12'h000};
        for (int i = 0; i < 14; i++) begin
            goto_a(35 * 800 + h_tab[i]);
            n_cmp++;
            if (rgb_a !== exp_tab[i]) begin
                n_err++;
                $display("FAIL bar_h%0d: got %h expected %h", h_tab[i], rgb_a, exp_tab[i]);
            end
        end
    endtask

    task automatic test_midframe_reset_a();
        goto_a(36 * 800 + 300);
        n_cmp++; if (rgb_a !== 12'hFF0) begin n_err++; $display("FAIL pre_reset_rgb_a: got %h expected FF0", rgb_a); end
        #1 rst_a = 1'b0;
        #1;
        n_cmp++; if ({hs_a, vs_a, rgb_a} !== 14'h0) begin n_err++; $display("FAIL async_reset_a: got %h expected 0", {hs_a, vs_a, rgb_a}); end
        @(negedge clk);
        rst_a = 1'b1;
        edges_a = 0;
        while (edges_a < 191) tick_a();
        n_cmp++; if (hs_a !== 1'b0) begin n_err++; $display("FAIL restart_hs_191: got %b expected 0", hs_a); end
        tick_a();
        n_cmp++; if (hs_a !== 1'b1) begin n_err++; $display("FAIL restart_hs_192: got %b expected 1", hs_a); end
        goto_a(1599);
        n_cmp++; if (vs_a !== 1'b0) begin n_err++; $display("FAIL restart_vs_line1: got %b expected 0", vs_a); end
        goto_a(1600);
        n_cmp++; if (vs_a !== 1'b1) begin n_err++; $display("FAIL restart_vs_line2: got %b expected 1", vs_a); end
    endtask

    task automatic test_vs_timing_b();
        int fall [2];
        int rise [2];
        int nf = 0;
        int nr = 0;
        int aligned = 0;
        logic pv, ph;
        fall = '{-1, -1};
        rise = '{-1, -1};
        @(negedge clk);
        rst_b = 1'b1;
        edges_b = 0;
        pv = vs_b;
        ph = hs_b;
        while (edges_b < 2400) begin
            tick_b();
            if (pv && !vs_b && nf < 2) begin
                fall[nf] = edges_b;
                nf++;
                if (ph && !hs_b) aligned++;
            end
            if (!pv && vs_b && nr < 2) begin rise[nr] = edges_b; nr++; end
            pv = vs_b;
            ph = hs_b;
        end
        n_cmp++; if (rise[0] !== 168) begin n_err++; $display("FAIL vs_first_rise: got %0d expected 168", rise[0]); end
        n_cmp++; if (fall[0] !== 1092) begin n_err++; $display("FAIL vs_first_fall: got %0d expected 1092", fall[0]); end
        n_cmp++; if (rise[1] - fall[0] !== 168) begin n_err++; $display("FAIL vs_low_width: got %0d expected 168", rise[1] - fall[0]); end
        n_cmp++; if (fall[1] - fall[0] !== 1092) begin n_err++; $display("FAIL vs_period: got %0d expected 1092", fall[1] - fall[0]); end
        n_cmp++; if (aligned !== 2) begin n_err++; $display("FAIL vs_hs_aligned: got %0d expected 2", aligned); end
    endtask

    task automatic test_midframe_reset_b();
        goto_b(728 + 7 * 28 + 12);
        n_cmp++; if (rgb_b !== 12'h0FF) begin n_err++; $display("FAIL pre_reset_rgb_b: got %h expected 0FF", rgb_b); end
        #1 rst_b = 1'b0;
        #1;
        n_cmp++; if ({hs_b, vs_b, rgb_b} !== 14'h0) begin n_err++; $display("FAIL async_reset_b: got %h expected 0", {hs_b, vs_b, rgb_b}); end
        @(negedge clk);
        rst_b = 1'b1;
        edges_b = 0;
        while (edges_b < 11) tick_b();
        n_cmp++; if (hs_b !== 1'b0) begin n_err++; $display("FAIL restart_b_hs_11: got %b expected 0", hs_b); end
        tick_b();
        n_cmp++; if (hs_b !== 1'b1) begin n_err++; $display("FAIL restart_b_hs_12: got %b expected 1", hs_b); end
    endtask

    task automatic test_vblank_bottom_b();
        int unsigned p_tab [9] = '{120, 148, 287, 288, 290, 301, 302, 304, 316};
        logic [11:0] e_tab [9] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'hFF0,
                                   12'h00F, 12'h000, 12'h000, 12'h000};
        for (int i = 0; i < 9; i++) begin
            goto_b(p_tab[i]);
            n_cmp++;
            if (rgb_b !== e_tab[i]) begin
                n_err++;
                $display("FAIL small_pix%0d: got %h expected %h", p_tab[i], rgb_b, e_tab[i]);
            end
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        test_reset();
        test_hs_timing();
        test_vblank_top();
        test_colour_bars();
        test_midframe_reset_a();
        test_vs_timing_b();
        test_midframe_reset_b();
        test_vblank_bottom_b();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
